// File: rtl/delay_line_tap_reader_if.sv
// ----------------------------------------------------------------------------
// delay_line_tap_reader_if
//
// Purpose: sample-stream bundle between the excitation/feedback mixer (master)
//          and the delay-line tap reader (slave).
//
// Signals:
//   in_valid      master->slave  sample strobe, may be high every cycle
//   in_data       master->slave  signed DATA_W-bit input sample
//   delay_length  master->slave  delay in samples, sampled on each strobe
//   out_valid     slave->master  one-cycle pulse per accepted sample
//   out_data      slave->master  delayed (optionally averaged) sample, held
//   primed        slave->master  high once the buffer holds >= L samples
// ----------------------------------------------------------------------------
interface delay_line_tap_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] delay_length;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              primed;

    modport master (
        output in_valid,
        output in_data,
        output delay_length,
        input  out_valid,
        input  out_data,
        input  primed
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  delay_length,
        output out_valid,
        output out_data,
        output primed
    );
endinterface : delay_line_tap_reader_if

// File: rtl/delay_line_tap_reader.sv
// ----------------------------------------------------------------------------
// delay_line_tap_reader
//
// Purpose: writes a strobed stream of signed samples into a 2^ADDR_W-entry
//          circular buffer and returns the sample written L accepts earlier,
//          two cycles after each accept. Entries not yet written since reset
//          read back as 0.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of delay_line_tap_reader_if
//
// Build option:
//   DELAY_TAP_AVERAGE_EN  when defined, out_data = (tap + tap_prev) >>> 1
//                         (Karplus-Strong two-tap lowpass); when undefined,
//                         out_data = tap and the averaging logic is absent.
// ----------------------------------------------------------------------------
module delay_line_tap_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    delay_line_tap_reader_if.slave   bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    // Write side
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill;
    logic              w_accept;
    logic [ADDR_W-1:0] w_len;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_fill_next;
    logic              w_sample_ok;

    // Storage
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ram_q;

    // Pipeline
    logic                     r_s1_valid;
    logic                     r_s1_ok;
    logic signed [DATA_W-1:0] w_tap;
    logic        [DATA_W-1:0] w_out_next;
    logic                     r_out_valid;
    logic        [DATA_W-1:0] r_out_data;
    logic                     r_primed;

    // ------------------------------------------------------------------------
    // Address / fill bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_accept    = bus.in_valid;
        w_len       = bus.delay_length;
        w_fill_next = r_fill;

        // A zero delay would read the slot being written; treat it as 1.
        if (bus.delay_length == '0) begin
            w_len = ADDR_W'(1);
        end

        // Modulo-2^ADDR_W subtraction handles wrap-around without a case.
        w_rd_addr = r_wr_ptr - w_len;

        // Validity is judged on the fill count before this accept's increment.
        w_sample_ok = (r_fill >= w_len);

        if (w_accept && (r_fill != FILL_MAX)) begin
            w_fill_next = r_fill + ADDR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_primed <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            r_fill   <= w_fill_next;
            r_primed <= (w_fill_next >= w_len);
        end
    end

    // ------------------------------------------------------------------------
    // Simple dual-port RAM, synchronous read
    // ------------------------------------------------------------------------
    // NOTE: the array and its read register have no reset so the RAM maps
    // onto block memory; stale contents are hidden by the fill mask instead.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
        r_ram_q <= r_mem[w_rd_addr];
    end

    // ------------------------------------------------------------------------
    // Stage 1: valid and mask bit travel alongside the RAM read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_ok    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_ok    <= w_accept & w_sample_ok;
        end
    end

    // Masked samples (not yet written since reset) become 0.
    assign w_tap = r_s1_ok ? $signed(r_ram_q) : '0;

    // ------------------------------------------------------------------------
    // Stage 2: output formation
    // ------------------------------------------------------------------------
`ifdef DELAY_TAP_AVERAGE_EN
    logic signed [DATA_W-1:0] r_tap_prev;
    logic signed [DATA_W:0]   w_sum;

    // One extra bit makes the sum overflow-free; >>> floors toward -inf and
    // the result always fits back into DATA_W bits.
    assign w_sum      = {w_tap[DATA_W-1], w_tap} + {r_tap_prev[DATA_W-1], r_tap_prev};
    assign w_out_next = DATA_W'(w_sum >>> 1);

    // Holds the previous output tap, not x[n-L-1], so a length change
    // blends across the discontinuity for one sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tap_prev <= '0;
        end else if (r_s1_valid) begin
            r_tap_prev <= w_tap;
        end
    end
`else
    assign w_out_next = w_tap;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_out_next;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.primed    = r_primed;

endmodule : delay_line_tap_reader

// File: tb/tb_delay_line_tap_reader.sv
// ----------------------------------------------------------------------------
// tb_delay_line_tap_reader
//
// Directed bench for delay_line_tap_reader. Expected values are hand-derived
// for both builds; the DELAY_TAP_AVERAGE_EN build selects the averaged set.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_delay_line_tap_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    logic clk;
    logic reset;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DELAY_TAP_AVERAGE_EN
    int exp_basic [10] = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 5};
    int exp_sf    [6]  = '{0, -2, -4, -5, 16381, 32767};
    int exp_rst   [5]  = '{0, 0, 0, 25, 50};
    int exp_len0  [3]  = '{0, 5, 11};
    int exp_sw    [4]  = '{101, 102, 106, 110};
`else
    int exp_basic [10] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6};
    int exp_sf    [6]  = '{0, -3, -4, -5, 32767, 32767};
    int exp_rst   [5]  = '{0, 0, 0, 50, 51};
    int exp_len0  [3]  = '{0, 11, 12};
    int exp_sw    [4]  = '{102, 103, 110, 111};
`endif

    delay_line_tap_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    delay_line_tap_reader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrap_exp(input int k);
`ifdef DELAY_TAP_AVERAGE_EN
        return (k >= 1024) ? k - 1024 : 0;
`else
        return (k >= 1023) ? k - 1023 : 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int exp);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 1);
        chk({tag, "_data"}, $signed(bus.out_data), exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic signed [DATA_W-1:0] d,
                          input logic [ADDR_W-1:0] len);
        bus.in_valid     = 1'b1;
        bus.in_data      = d;
        bus.delay_length = len;
        tick();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.delay_length = '0;

        // Reset state, asserted before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_valid",  {31'd0, bus.out_valid}, 0);
        chk("rst_data",   $signed(bus.out_data), 0);
        chk("rst_primed", {31'd0, bus.primed}, 0);
        tick();
        reset = 1'b0;

        // Basic delay, L = 4, inputs 1..10
        for (int i = 0; i < 10; i++) begin
            accept(DATA_W'(i + 1), 10'd4);
            if (i == 0) chk("basic_lat", {31'd0, bus.out_valid}, 0);
            else        chk_out($sformatf("basic%0d", i - 1), exp_basic[i-1]);
            if (i == 2) chk("basic_primed3", {31'd0, bus.primed}, 0);
            if (i == 3) chk("basic_primed4", {31'd0, bus.primed}, 1);
        end
        idle();
        chk_out("basic9", exp_basic[9]);
        idle();
        chk("basic_idle_valid", {31'd0, bus.out_valid}, 0);
        chk("basic_hold", $signed(bus.out_data), exp_basic[9]);

        // Signed floor and no overflow, L = 1
        do_reset();
        accept(-16'sd3, 10'd1);
        accept(-16'sd4, 10'd1);
        chk_out("sf0", exp_sf[0]);
        accept(-16'sd5, 10'd1);
        chk_out("sf1", exp_sf[1]);
        accept(16'sd32767, 10'd1);
        chk_out("sf2", exp_sf[2]);
        accept(16'sd32767, 10'd1);
        chk_out("sf3", exp_sf[3]);
        accept(16'sd0, 10'd1);
        chk_out("sf4", exp_sf[4]);
        idle();
        chk_out("sf5", exp_sf[5]);

        // Wrap, L = 1023, 2100 continuous accepts
        do_reset();
        for (int k = 0; k < 2100; k++) begin
            accept(DATA_W'(k), 10'd1023);
            if (k >= 1) chk_out($sformatf("wrap%0d", k - 1), wrap_exp(k - 1));
        end
        idle();
        chk_out("wrap2099", wrap_exp(2099));

        // Reset mid-stream, L = 3
        do_reset();
        for (int i = 0; i < 6; i++) accept(DATA_W'(i + 1), 10'd3);
        chk("mid_pre_valid", {31'd0, bus.out_valid}, 1);
        chk("mid_pre_primed", {31'd0, bus.primed}, 1);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_valid",  {31'd0, bus.out_valid}, 0);
        chk("mid_data",   $signed(bus.out_data), 0);
        chk("mid_primed", {31'd0, bus.primed}, 0);
        tick();
        reset = 1'b0;
        accept(16'sd50, 10'd3);
        chk("mid_drop", {31'd0, bus.out_valid}, 0);
        accept(16'sd51, 10'd3);
        chk_out("mid0", exp_rst[0]);
        accept(16'sd52, 10'd3);
        chk_out("mid1", exp_rst[1]);
        accept(16'sd53, 10'd3);
        chk_out("mid2", exp_rst[2]);
        accept(16'sd54, 10'd3);
        chk_out("mid3", exp_rst[3]);
        idle();
        chk_out("mid4", exp_rst[4]);

        // delay_length = 0 behaves as 1
        do_reset();
        accept(16'sd11, 10'd0);
        chk("len0_primed", {31'd0, bus.primed}, 1);
        accept(16'sd12, 10'd0);
        chk_out("len0_0", exp_len0[0]);
        accept(16'sd13, 10'd0);
        chk_out("len0_1", exp_len0[1]);
        idle();
        chk_out("len0_2", exp_len0[2]);

        // Switch 8 -> 2 mid-stream
        do_reset();
        for (int i = 0; i < 12; i++) accept(DATA_W'(100 + i), 10'd8);
        chk_out("sw_a", exp_sw[0]);
        accept(16'sd200, 10'd2);
        chk_out("sw_b", exp_sw[1]);
        accept(16'sd201, 10'd2);
        chk_out("sw_c", exp_sw[2]);
        idle();
        chk_out("sw_d", exp_sw[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_delay_line_tap_reader
